luma_stream_ctrl: RTL and testbench
===================================

Name: luma_stream_ctrl

Overview:
Sequences the RGB565→Y converter (YCrCb) for the edge-detect front end. It accepts a framed RGB565 pixel stream with a valid/ready handshake and feeds the free-running converter. It tracks in-flight pixels through the converter's fixed latency and buffers Y results in an output FIFO, so downstream back-pressure never drops a pixel. It also checks line/frame geometry, counts completed frames and handles start/stop at frame boundaries.

Parameters:
CONV_LAT, 2, YCrCb latency in cycles from R/G/B input change to Y valid
FIFO_DEPTH, 8, output FIFO entries (power of 2, ≥ CONV_LAT+1)
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  run request; sampled each cycle
in_valid  in  1  input pixel valid
in_ready  out  1  controller can accept a pixel
in_rgb  in  16  {R[4:0],G[5:0],B[4:0]}
in_sof  in  1  first pixel of frame
in_eol  in  1  last pixel of line
out_valid  out  1  Y word available
out_ready  in  1  downstream accepts
out_y  out  8  luma
out_sof  out  1  luma word is first of frame
out_eol  out  1  luma word is last of line
out_eof  out  1  luma word is last of frame
frame_cnt  out  16  completed input frames, wraps
err_line  out  1  sticky line-length error
err_sof  out  1  sticky unexpected-SOF error
err_clr  in  1  clears both sticky errors (one cycle)
busy  out  1  state≠IDLE, or pixels in flight, or FIFO non-empty

Behaviour:
- Reset (async): state IDLE; FIFO empty; tag pipe cleared; x=y=0; frame_cnt=0; err_*=0; in_ready=0, out_valid=0, out_y/out_sof/out_eol/out_eof=0, busy=0. The converter rst is tied to rst. Reset mid-frame discards all in-flight and buffered data.
- occ = in-flight count + FIFO count. credit = (occ < FIFO_DEPTH). A pop frees credit only on the following cycle.
- in_ready = credit when state is SYNC, ACTIVE or DRAIN; otherwise 0. accept = in_valid & in_ready.
- FSM:
  - IDLE: en=1 → SYNC.
  - SYNC: an accepted pixel without sof is discarded (it does not enter the converter). An accepted pixel with sof enters the converter; set x=0, y=0; go to ACTIVE. en=0 → IDLE.
  - ACTIVE: accepted pixels go to the converter. en=0 → DRAIN.
  - DRAIN: same as ACTIVE. On the frame-ending pixel → IDLE.
  - ACTIVE, frame-ending pixel with en=1 → SYNC.
- Frame-ending pixel = accepted in_eol with y==V_ACTIVE-1. On it: frame_cnt+1, and the pixel's tag sets eof.
- Geometry (on accept, ACTIVE/DRAIN):
  - Non-eol pixel: x+1, saturating at H_ACTIVE-1.
  - eol pixel: x←0, y+1.
  - err_line set if eol with x≠H_ACTIVE-1, or non-eol with x==H_ACTIVE-1.
  - sof pixel in ACTIVE/DRAIN: err_sof set; x,y restart as a new frame; no frame_cnt increment.
- Error flags: err_clr clears both; a set event in the same cycle wins.
- Datapath:
  - On accept, in_rgb is registered onto converter R/G/B (held otherwise).
  - A tag shift register of depth CONV_LAT+1 carries {valid,sof,eol,eof}.
  - At tag exit, Y plus flags are pushed into the FIFO. The push cannot overflow by construction; an assertion checks this.
- Latency: pixel accepted at edge k with FIFO empty and out_ready=1 → out_valid high after edge k+CONV_LAT+1. Throughput is 1 pixel/clk when out_ready=1.
- FIFO: first-word-fall-through. Pop = out_valid & out_ready. Simultaneous push/pop is legal at any count. Output order equals accept order.
- out_* signals are stable while out_valid=1 and out_ready=0.

Decomposition:
- Package luma_pkg:
  - RGB565 field slices.
  - Tag struct/constants {valid,sof,eol,eof}.
  - State encoding IDLE/SYNC/ACTIVE/DRAIN.
- Sub-module luma_fifo: parameterised sync FWFT FIFO (width 11 = Y + 3 flags), count output.
- The existing YCrCb is instantiated unmodified.

Test Plan:
- Reset mid-stream (rst pulse at arbitrary time) → in_ready=0, out_valid=0, frame_cnt=0, busy=0 immediately. No stale output after reset release.
- H_ACTIVE=4, V_ACTIVE=2, en=1: one sof pixel RGB=0x0000 → out_valid after edge k+CONV_LAT+1, out_y=0, out_sof=1. A second pixel 0xFFFF gives out_y equal to the YCrCb model for R=31,G=63,B=31.
- out_ready=0, 12 pixels offered, FIFO_DEPTH=8 → exactly 8 accepted, then in_ready=0. Raise out_ready → the 8 Y words arrive in order with correct eol flags, then acceptance resumes.
- SYNC: 5 pixels without sof → all accepted, zero outputs, busy stays 1 only for state. Then a sof pixel → output begins with out_sof=1.
- eol at x=2 (H_ACTIVE=4) → err_line=1 persists. err_clr pulse → 0. Simultaneous err_clr and a new error → stays 1.
- en dropped after the first line of a 4×2 frame → remaining 4 pixels still accepted, out_eof on the 8th word, frame_cnt=1, then IDLE with in_ready=0.

Source files
------------

// File: rtl/luma_pkg.sv
// luma_pkg: shared types for the RGB565-to-luma stream controller.
package luma_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DRAIN} state_t;
  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
    logic eof;
  } tag_t;
  localparam int FIFO_W = 11;
  function automatic logic [4:0] rgb_r(input logic [15:0] p);
    return p[15:11];
  endfunction
  function automatic logic [5:0] rgb_g(input logic [15:0] p);
    return p[10:5];
  endfunction
  function automatic logic [4:0] rgb_b(input logic [15:0] p);
    return p[4:0];
  endfunction
endpackage

// File: rtl/luma_stream_ctrl_if.sv
// luma_stream_ctrl_if: RGB565 input stream and luma output stream handshakes.
interface luma_stream_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic [15:0] in_rgb;
  logic in_sof;
  logic in_eol;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_y;
  logic out_sof;
  logic out_eol;
  logic out_eof;
  modport master (
    output in_valid, in_rgb, in_sof, in_eol, out_ready,
    input in_ready, out_valid, out_y, out_sof, out_eol, out_eof
  );
  modport slave (
    input in_valid, in_rgb, in_sof, in_eol, out_ready,
    output in_ready, out_valid, out_y, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/YCrCb.sv
// YCrCb: free-running RGB565 to 8-bit luma, two-cycle latency, weights 77/150/29 over 256.
module YCrCb (
  input logic clk,
  input logic rst,
  input logic [4:0] r,
  input logic [5:0] g,
  input logic [4:0] b,
  output logic [7:0] y
);
  logic [7:0] y1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y1 <= '0;
      y <= '0;
    end else begin
      y1 <= 8'((77 * {r, r[4:2]} + 150 * {g, g[5:4]} + 29 * {b, b[4:2]}) >> 8);
      y <= y1;
    end
endmodule

// File: rtl/luma_fifo.sv
// luma_fifo: synchronous first-word-fall-through FIFO; data reads as zero while empty.
module luma_fifo #(
  parameter int W = 11,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic [W-1:0] din,
  input logic pop,
  output logic [W-1:0] dout,
  output logic valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic take;
  assign valid = count != '0;
  assign take = pop & valid;
  assign dout = valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (take) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, take};
    end
  // the controller's credit scheme keeps a free slot for every pixel in flight
  no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> count < DEPTH);
endmodule

// File: rtl/luma_stream_ctrl.sv
// luma_stream_ctrl: framed RGB565 front end for YCrCb with credit-limited in-flight
// tracking, FWFT luma buffering, line/frame geometry checks and frame counting.
module luma_stream_ctrl
  import luma_pkg::*;
#(
  parameter int CONV_LAT = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic err_clr,
  luma_stream_ctrl_if.slave bus,
  output logic [15:0] frame_cnt,
  output logic err_line,
  output logic err_sof,
  output logic busy
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int OW = $clog2(FIFO_DEPTH) + 2;
  state_t state, nxt;
  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic [OW-2:0] fifo_cnt;
  logic [OW-1:0] inflight, occ;
  tag_t [CONV_LAT:0] tags;
  tag_t tag_in, tag_out;
  logic [15:0] rgb_q;
  logic [7:0] y_conv;
  logic [FIFO_W-1:0] dout;
  logic acc, enter, last_x, f_end, line_err, sof_err;
  // every pixel in the tag pipe already owns a FIFO slot, so pushes never overflow
  assign occ = inflight + OW'(fifo_cnt);
  assign bus.in_ready = (state != IDLE) && (occ < OW'(FIFO_DEPTH));
  assign acc = bus.in_valid & bus.in_ready;
  assign enter = acc & ((state != SYNC) | bus.in_sof);
  assign cx = bus.in_sof ? '0 : x;
  assign cy = bus.in_sof ? '0 : y;
  assign last_x = cx == XW'(H_ACTIVE - 1);
  assign f_end = enter & bus.in_eol & (cy == YW'(V_ACTIVE - 1));
  assign line_err = enter & (bus.in_eol ^ last_x);
  assign sof_err = enter & bus.in_sof & (state inside {ACTIVE, DRAIN});
  assign tag_in = '{valid: enter, sof: bus.in_sof, eol: bus.in_eol, eof: f_end};
  assign tag_out = tags[CONV_LAT];
  assign busy = (state != IDLE) | (occ != '0);
  assign {bus.out_y, bus.out_sof, bus.out_eol, bus.out_eof} = dout;
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= CONV_LAT; i++) inflight += OW'(tags[i].valid);
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   nxt = en ? SYNC : IDLE;
      SYNC:   nxt = f_end ? (en ? SYNC : IDLE) : enter ? ACTIVE : en ? SYNC : IDLE;
      ACTIVE: nxt = f_end ? (en ? SYNC : IDLE) : en ? ACTIVE : DRAIN;
      DRAIN:  nxt = f_end ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      frame_cnt <= '0;
      err_line <= 1'b0;
      err_sof <= 1'b0;
      rgb_q <= '0;
      tags <= '0;
    end else begin
      state <= nxt;
      if (enter) begin
        x <= bus.in_eol ? '0 : last_x ? cx : cx + 1'b1;
        y <= f_end ? '0 : bus.in_eol ? cy + 1'b1 : cy;
        rgb_q <= bus.in_rgb;
      end
      if (f_end) frame_cnt <= frame_cnt + 1'b1;
      err_line <= line_err | (err_line & ~err_clr);
      err_sof <= sof_err | (err_sof & ~err_clr);
      tags <= {tags[CONV_LAT-1:0], tag_in};
    end
  YCrCb conv (
    .clk(clk),
    .rst(rst),
    .r(rgb_r(rgb_q)),
    .g(rgb_g(rgb_q)),
    .b(rgb_b(rgb_q)),
    .y(y_conv)
  );
  luma_fifo #(.W(FIFO_W), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .push(tag_out.valid),
    .din({y_conv, tag_out.sof, tag_out.eol, tag_out.eof}),
    .pop(bus.out_ready),
    .dout(dout),
    .valid(bus.out_valid),
    .count(fifo_cnt)
  );
endmodule

// File: tb/tb_luma_stream_ctrl.sv
// tb_luma_stream_ctrl: directed scoreboard bench for a 4x2-pixel frame geometry.
module tb_luma_stream_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic err_clr = 1'b0;
  logic [15:0] frame_cnt;
  logic err_line, err_sof, busy;
  int errors = 0;
  int checks = 0;
  logic [10:0] q[$];
  logic [15:0] col[6] = '{16'h0000, 16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h8410};
  logic [7:0] ycol[6] = '{8'd0, 8'd255, 8'd76, 8'd149, 8'd28, 8'd130};
  luma_stream_ctrl_if bus();
  luma_stream_ctrl #(.CONV_LAT(2), .FIFO_DEPTH(8), .H_ACTIVE(4), .V_ACTIVE(2)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .err_clr(err_clr),
    .bus(bus),
    .frame_cnt(frame_cnt),
    .err_line(err_line),
    .err_sof(err_sof),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  task automatic send(input logic [15:0] rgb, input logic sof, input logic eol, input logic eof,
                      input logic [7:0] ey, input logic keep);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_rgb = rgb;
    bus.in_sof = sof;
    bus.in_eol = eol;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", bus.in_ready, 1);
    if (bus.in_ready && keep) q.push_back({ey, sof, eol, eof});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  wire [10:0] got = {bus.out_y, bus.out_sof, bus.out_eol, bus.out_eof};
  logic stall = 1'b0;
  logic [10:0] held = '0;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (stall) chk("hold", {bus.out_valid, got}, {1'b1, held});
      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", q.size() != 0, 1);
        if (q.size() != 0) chk("out_word", got, q.pop_front());
      end
    end
    stall <= !rst && bus.out_valid && !bus.out_ready;
    held <= got;
  end
  initial begin
    int idx;
    bus.in_valid = 1'b0;
    bus.in_rgb = '0;
    bus.in_sof = 1'b0;
    bus.in_eol = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err_line, err_sof}, 0);
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(col[i%6], i == 0, i % 4 == 3, i == 7, ycol[i%6], 1'b1);
      if (i == 0)
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("latency_%0d", c), bus.out_valid, c == 3);
          @(negedge clk);
        end
    end
    drain();
    chk("frame_cnt_a", frame_cnt, 1);
    chk("err_a", {err_line, err_sof}, 0);
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 12; c++) begin
      if (c == 20) begin
        chk("bp_accepted", idx, 8);
        chk("bp_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
      end
      bus.in_valid = 1'b1;
      bus.in_rgb = col[idx%6];
      bus.in_sof = idx == 0;
      bus.in_eol = idx % 4 == 3;
      if (bus.in_ready) begin
        if (idx < 8) q.push_back({ycol[idx%6], idx == 0, idx % 4 == 3, idx == 7});
        idx++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("bp_resume", idx, 12);
    drain();
    chk("frame_cnt_b", frame_cnt, 2);
    for (int i = 0; i < 5; i++) begin
      send(col[i], 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      chk("sync_busy", busy, 1);
      chk("sync_no_out", bus.out_valid, 0);
    end
    send(col[1], 1'b1, 1'b0, 1'b0, ycol[1], 1'b1);
    send(col[2], 1'b0, 1'b0, 1'b0, ycol[2], 1'b1);
    send(col[3], 1'b0, 1'b1, 1'b0, ycol[3], 1'b1);
    chk("err_line_set", err_line, 1);
    for (int i = 0; i < 4; i++) send(col[i], 1'b0, i == 3, i == 3, ycol[i], 1'b1);
    drain();
    chk("err_line_persist", err_line, 1);
    chk("err_sof_d", err_sof, 0);
    chk("frame_cnt_d", frame_cnt, 3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", err_line, 0);
    send(col[4], 1'b1, 1'b0, 1'b0, ycol[4], 1'b1);
    err_clr = 1'b1;
    send(col[5], 1'b0, 1'b1, 1'b0, ycol[5], 1'b1);
    err_clr = 1'b0;
    chk("err_clr_vs_set", err_line, 1);
    send(col[0], 1'b1, 1'b0, 1'b0, ycol[0], 1'b1);
    chk("err_sof_set", err_sof, 1);
    for (int i = 1; i < 8; i++) send(col[i%6], 1'b0, i % 4 == 3, i == 7, ycol[i%6], 1'b1);
    drain();
    chk("frame_cnt_e", frame_cnt, 4);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_both_clr", {err_line, err_sof}, 0);
    for (int i = 0; i < 8; i++) begin
      send(col[(i+3)%6], i == 0, i % 4 == 3, i == 7, ycol[(i+3)%6], 1'b1);
      if (i == 3) en = 1'b0;
    end
    chk("drain_in_ready", bus.in_ready, 0);
    drain();
    chk("frame_cnt_f", frame_cnt, 5);
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", bus.in_ready, 0);
    en = 1'b1;
    bus.out_ready = 1'b0;
    send(col[1], 1'b1, 1'b0, 1'b0, ycol[1], 1'b1);
    send(col[2], 1'b0, 1'b0, 1'b0, ycol[2], 1'b1);
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_y", got, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_no_out", bus.out_valid, 0);
    end
    chk("sb_empty_end", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
